// File: rtl/ofdm_pkg.sv
// ofdm_pkg: frame geometry and FSM state type shared by the cyclic-prefix serializer and deserializer
package ofdm_pkg;
  localparam int DATA_W    = 16;
  localparam int N_FFT     = 16;
  localparam int CP_LEN    = 3;
  localparam int FRAME_LEN = CP_LEN + N_FFT;
  typedef enum logic {CP, BODY} state_e;
endpackage

// File: rtl/cp_deserializer.sv
// cp_deserializer: strips the cyclic prefix, checks it against the symbol tail, packs the body into one wide word
module cp_deserializer #(
  parameter int DATA_W   = ofdm_pkg::DATA_W,
  parameter int N_FFT    = ofdm_pkg::N_FFT,
  parameter int CP_LEN   = ofdm_pkg::CP_LEN,
  parameter int CP_CHECK = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      valid_in,
  output logic [N_FFT*DATA_W-1:0]   sym_out,
  output logic                      valid_out,
  output logic                      cp_mismatch
);
  import ofdm_pkg::*;
  localparam int CNT_W = $clog2(N_FFT);
  localparam int CP_W  = (CP_LEN > 1) ? $clog2(CP_LEN) : 1;
  localparam int TAIL  = N_FFT - CP_LEN;
  localparam int SYM_W = N_FFT * DATA_W;
  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   cp_buf_q [CP_LEN];
  logic [SYM_W-1:0]    sh_q, sym_q;
  logic                mis_q, valid_q, cpm_q;
  logic                last_cp, last_body, in_tail, mis_d;
  logic [CP_W-1:0]     cp_idx, tail_idx;
  logic [SYM_W-1:0]    sh_d;
  assign last_cp   = cnt_q == CNT_W'(CP_LEN - 1);
  assign last_body = cnt_q == CNT_W'(N_FFT - 1);
  assign cp_idx    = cnt_q[CP_W-1:0];
  assign in_tail   = cnt_q >= CNT_W'(TAIL);
  assign tail_idx  = in_tail ? CP_W'(cnt_q - CNT_W'(TAIL)) : '0;
  assign mis_d     = mis_q | (in_tail && data_in != cp_buf_q[tail_idx]);
  assign sh_d      = {sh_q[SYM_W-DATA_W-1:0], data_in};
  // Frame FSM: fill prefix buffer, then shift in the body while folding the tail compare into a sticky flag
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= CP;
      cnt_q   <= '0;
      for (int j = 0; j < CP_LEN; j++) cp_buf_q[j] <= '0;
      sh_q    <= '0;
      sym_q   <= '0;
      mis_q   <= 1'b0;
      valid_q <= 1'b0;
      cpm_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (valid_in) begin
        if (state_q == CP) begin
          cp_buf_q[cp_idx] <= data_in;
          if (cnt_q == '0) mis_q <= 1'b0;
          cnt_q   <= last_cp ? '0 : cnt_q + 1'b1;
          state_q <= last_cp ? BODY : CP;
        end else begin
          sh_q    <= sh_d;
          mis_q   <= mis_d;
          cnt_q   <= last_body ? '0 : cnt_q + 1'b1;
          state_q <= last_body ? CP : BODY;
          if (last_body) begin
            sym_q   <= sh_d;
            valid_q <= 1'b1;
            cpm_q   <= (CP_CHECK != 0) && mis_d;
          end
        end
      end
    end
  assign sym_out     = sym_q;
  assign valid_out   = valid_q;
  assign cp_mismatch = cpm_q;
endmodule

// File: doc/cp_deserializer.md
# cp_deserializer

Receive-side counterpart of the cyclic-prefix serializer. Accepts a stream of 16-bit time-domain words, one per qualified cycle. Each frame is 19 words: a 3-word cyclic prefix followed by 16 symbol samples. The block discards the prefix, checks it against the symbol tail, and presents the 16 samples as one 256-bit parallel word with a single-cycle strobe for the downstream FFT stage.

## Interface
- `DATA_W`, 16: sample width in bits.
- `N_FFT`, 16: symbol samples per frame.
- `CP_LEN`, 3: cyclic-prefix words per frame (1 ≤ CP_LEN < N_FFT).
- `CP_CHECK`, 1: when 1, enable the prefix-versus-tail comparison; when 0, `cp_mismatch` is tied low.
- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: asynchronous, active-low reset.
- `data_in`  in  DATA_W: serial sample word.
- `valid_in`  in  1: qualifies `data_in` in this cycle.
- `sym_out`  out  N_FFT*DATA_W: assembled symbol.
- `valid_out`  out  1: one-cycle strobe; `sym_out` is new.
- `cp_mismatch`  out  1: valid with `valid_out`; prefix differs from the symbol tail.

## Operation
- Frame length: FRAME_LEN = CP_LEN + N_FFT (19). Frame alignment is set by reset: the first accepted word after reset is word 0 of a frame.
- A word is accepted on a rising edge with `valid_in` = 1. With `valid_in` = 0, counters, buffers and state hold. Gaps of any length are allowed mid-frame.
- FSM states:
  - **CP**: accept words 0..CP_LEN-1 into the prefix buffer `cp_buf[j]`, j = 0..CP_LEN-1. After word CP_LEN-1 is accepted, go to BODY.
  - **BODY**: accept body word k (k = 0..N_FFT-1) into the shift register. After body word N_FFT-1 is accepted, go to CP and update the outputs at that same edge.
- Packing: the first body word lands in the MSBs. Body word k maps to `sym_out[(N_FFT-1-k)*DATA_W +: DATA_W]`, which matches the serializer's MSB-first word order.
- Prefix check:
  - `cp_buf[j]` is compared with body word N_FFT-CP_LEN+j.
  - Comparison is incremental: a sticky mismatch flag is updated as each tail word arrives.
  - The flag is cleared when the next frame's CP state begins.
- Outputs:
  - `sym_out` holds its value until the next frame completes.
  - `cp_mismatch` holds its value until the next `valid_out`.
  - Data is never dropped; there is no backpressure input.
- Back-to-back frames: word 0 of the next frame may be accepted in the cycle immediately after the last body word. No bubble is required.

## Timing
- Reset values (asynchronous, on `reset` = 0): state = CP, word counter = 0, `cp_buf` = 0, shift register = 0, `sym_out` = 0, `valid_out` = 0, `cp_mismatch` = 0.
- Latency: if the final body word is accepted at edge E, `sym_out` and `cp_mismatch` update at E, and `valid_out` is high from E to E+1 (exactly one cycle).
- `valid_out` never stays high for two consecutive cycles. Minimum spacing between strobes is FRAME_LEN cycles.
- Reset asserted mid-frame: the partial frame is discarded with no `valid_out`. The first word accepted after reset release is treated as prefix word 0.
- Reset asserted in the same cycle as the final body word: reset wins, and `valid_out` stays 0.
- Counter wrap: the body counter wraps from N_FFT-1 to 0 and the prefix counter from CP_LEN-1 to 0. There is no other terminal condition.

## Structure
- Shared package `ofdm_pkg`:
  - constants `DATA_W`, `N_FFT`, `CP_LEN`, `FRAME_LEN`;
  - FSM state type {CP, BODY};
  - the same constants also serve `cp_serializer`.
- Single module; no sub-module. The counter, prefix buffer, shift register and compare logic are all inline. The RTL target is about 150–200 lines.

## Test plan
- **Reset values and single frame, no mismatch.** Hold `reset` low for 2 cycles and check every output is 0. Then send 19 back-to-back words: prefix 000D,000E,000F followed by body 0000..000F. Required response: one `valid_out` pulse, `sym_out` = 0000_0001_…_000F with word 0 in the MSBs, `cp_mismatch` = 0.
- **Prefix mismatch.** Same frame with prefix 000D,FFFF,000F. Required response: `valid_out` pulses, `sym_out` is unchanged from the previous case, `cp_mismatch` = 1.
- **Gapped input.** Send the first frame with `valid_in` dropped for 3 cycles after words 2 and 10. Required response: an identical `sym_out`, with `valid_out` arriving 6 cycles later than the gap-free case.
- **Back-to-back frames.** Send two frames, 38 consecutive valid words: the first with body 0001..0010 and correct prefix, the second with body FFF0..FFFF and wrong prefix. Required response: two strobes exactly 19 cycles apart, each `sym_out` correct, `cp_mismatch` = 0 then 1.
- **Reset mid-frame.** After 10 words, pulse `reset` low, then send one full frame. Required response: no strobe for the partial frame, exactly one strobe with the full frame's data.
- **CP_CHECK = 0 build.** Repeat the mismatch case. Required response: `cp_mismatch` stays 0 and `sym_out` is unchanged.
